// File: rtl/turn_controller.sv
// Two-player turn sequencer for the artillery game: per-player aim state,
// fire/launch handshake with the shared bomb, flight timeout and turn swap.
module turn_controller #(
  parameter int SETTLE_FRAMES  = 30,
  parameter int FLIGHT_TIMEOUT = 600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_fire,
  input  logic [9:0] tank0_x,
  input  logic [9:0] tank0_y,
  input  logic [9:0] tank1_x,
  input  logic [9:0] tank1_y,
  input  logic       bomb_done,
  output logic       launch,
  output logic [9:0] launchX,
  output logic [9:0] launchY,
  output logic [3:0] angle,
  output logic [2:0] power,
  output logic       active_player,
  output logic       busy,
  output logic [7:0] turn_count
);

  localparam logic [2:0] S_AIM    = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_FLIGHT = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_SWAP   = 3'd4;

  localparam logic [9:0] LP_TIMEOUT = 10'(FLIGHT_TIMEOUT);
  localparam logic [9:0] LP_SETTLE  = 10'(SETTLE_FRAMES);

  logic [2:0] r_state;
  logic       r_launch;
  logic       r_busy;
  logic       r_active;
  logic [7:0] r_turn;
  logic [9:0] r_launch_x;
  logic [9:0] r_launch_y;
  logic [4:0] r_prev;   // {left, right, up, down, fire}
  logic       r_armed;
  logic [9:0] r_cnt;
  logic [3:0] r_angle [2];
  logic [2:0] r_power [2];

  logic       w_press_left, w_press_right, w_press_up, w_press_down, w_press_fire;
  logic [3:0] w_cur_angle, w_angle_next;
  logic [2:0] w_cur_power, w_power_next;
  logic [9:0] w_cnt_inc;

  assign w_press_left  = frame_tick & key_left  & ~r_prev[4];
  assign w_press_right = frame_tick & key_right & ~r_prev[3];
  assign w_press_up    = frame_tick & key_up    & ~r_prev[2];
  assign w_press_down  = frame_tick & key_down  & ~r_prev[1];
  assign w_press_fire  = frame_tick & key_fire  & ~r_prev[0];

  assign w_cur_angle = r_angle[r_active];
  assign w_cur_power = r_power[r_active];
  assign w_cnt_inc   = (r_cnt == 10'h3FF) ? r_cnt : r_cnt + 10'd1;

  // Opposing presses in the same frame cancel; both ends saturate.
  always_comb begin
    w_angle_next = w_cur_angle;
    w_power_next = w_cur_power;
    if (w_press_left && !w_press_right && w_cur_angle != 4'd0)
      w_angle_next = w_cur_angle - 4'd1;
    else if (w_press_right && !w_press_left && w_cur_angle != 4'd8)
      w_angle_next = w_cur_angle + 4'd1;
    if (w_press_up && !w_press_down && w_cur_power != 3'd7)
      w_power_next = w_cur_power + 3'd1;
    else if (w_press_down && !w_press_up && w_cur_power != 3'd0)
      w_power_next = w_cur_power - 3'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the two-entry aim arrays are small enough to
  // carry real reset values like any other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_AIM;
      r_launch   <= 1'b0;
      r_busy     <= 1'b0;
      r_active   <= 1'b0;
      r_turn     <= 8'd0;
      r_launch_x <= 10'd0;
      r_launch_y <= 10'd0;
      r_prev     <= 5'd0;
      r_armed    <= 1'b0;
      r_cnt      <= 10'd0;
      r_angle[0] <= 4'd6;
      r_angle[1] <= 4'd2;
      r_power[0] <= 3'd3;
      r_power[1] <= 3'd3;
    end else begin
      if (frame_tick) r_prev <= {key_left, key_right, key_up, key_down, key_fire};

      case (r_state)
        S_AIM: begin
          if (frame_tick) begin
            r_angle[r_active] <= w_angle_next;
            r_power[r_active] <= w_power_next;
            if (w_press_fire) begin
              r_launch_x <= r_active ? tank1_x : tank0_x;
              r_launch_y <= r_active ? tank1_y : tank0_y;
              r_state    <= S_LAUNCH;
              r_launch   <= 1'b1;
              r_busy     <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          if (frame_tick) begin
            r_state  <= S_FLIGHT;
            r_launch <= 1'b0;
            r_armed  <= 1'b0;
            r_cnt    <= 10'd0;
          end
        end
        S_FLIGHT: begin
          // bomb_done is stale-high until the bomb has been seen in flight.
          if (frame_tick) begin
            r_cnt <= w_cnt_inc;
            if (!bomb_done) r_armed <= 1'b1;
            if ((bomb_done && r_armed) || (w_cnt_inc >= LP_TIMEOUT)) begin
              r_state <= S_SETTLE;
              r_cnt   <= 10'd0;
            end
          end
        end
        S_SETTLE: begin
          if (SETTLE_FRAMES == 0) begin
            r_state <= S_SWAP;
          end else if (frame_tick) begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc >= LP_SETTLE) r_state <= S_SWAP;
          end
        end
        S_SWAP: begin
          r_active <= ~r_active;
          r_turn   <= r_turn + 8'd1;
          r_state  <= S_AIM;
          r_busy   <= 1'b0;
          r_cnt    <= 10'd0;
        end
        default: begin
          r_state  <= S_AIM;
          r_launch <= 1'b0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign launch        = r_launch;
  assign launchX       = r_launch_x;
  assign launchY       = r_launch_y;
  assign angle         = w_cur_angle;
  assign power         = w_cur_power;
  assign active_player = r_active;
  assign busy          = r_busy;
  assign turn_count    = r_turn;

endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: aim saturation, fire/launch timing,
// arming, detonation, flight timeout, held fire across swap, async reset.
module tb_turn_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       key_left = 1'b0, key_right = 1'b0, key_up = 1'b0, key_down = 1'b0, key_fire = 1'b0;
  logic [9:0] tank0_x = 10'd100, tank0_y = 10'd400, tank1_x = 10'd200, tank1_y = 10'd300;
  logic       bomb_done = 1'b1;
  logic       launch;
  logic [9:0] launchX, launchY;
  logic [3:0] angle;
  logic [2:0] power;
  logic       active_player, busy;
  logic [7:0] turn_count;

  int checks = 0;
  int errors = 0;

  turn_controller #(.SETTLE_FRAMES(3), .FLIGHT_TIMEOUT(10)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .key_left(key_left), .key_right(key_right), .key_up(key_up),
    .key_down(key_down), .key_fire(key_fire),
    .tank0_x(tank0_x), .tank0_y(tank0_y), .tank1_x(tank1_x), .tank1_y(tank1_y),
    .bomb_done(bomb_done), .launch(launch), .launchX(launchX), .launchY(launchY),
    .angle(angle), .power(power), .active_player(active_player), .busy(busy),
    .turn_count(turn_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // One-clk frame strobe; returns at the negedge after the strobed posedge.
  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    checks++; if (angle !== 4'd6) begin errors++; $display("FAIL reset_angle got %0d exp 6", angle); end
    checks++; if (power !== 3'd3) begin errors++; $display("FAIL reset_power got %0d exp 3", power); end
    checks++; if (active_player !== 1'b0) begin errors++; $display("FAIL reset_player got %0b exp 0", active_player); end
    checks++; if (launch !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_launch_busy got %0b%0b exp 00", launch, busy); end
    checks++; if (turn_count !== 8'd0 || launchX !== 10'd0) begin errors++; $display("FAIL reset_turn_lx got %0d/%0d exp 0/0", turn_count, launchX); end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_aim();
    for (int i = 0; i < 3; i++) begin
      key_right = 1'b1; tick(); key_right = 1'b0; tick();
    end
    checks++; if (angle !== 4'd8) begin errors++; $display("FAIL angle_sat_hi got %0d exp 8", angle); end
    for (int i = 0; i < 5; i++) begin
      key_up = 1'b1; tick(); key_up = 1'b0; tick();
    end
    checks++; if (power !== 3'd7) begin errors++; $display("FAIL power_sat_hi got %0d exp 7", power); end
    key_left = 1'b1; key_right = 1'b1; tick(); key_left = 1'b0; key_right = 1'b0; tick();
    checks++; if (angle !== 4'd8) begin errors++; $display("FAIL left_right_cancel got %0d exp 8", angle); end
    key_left = 1'b1; tick();
    checks++; if (angle !== 4'd7) begin errors++; $display("FAIL left_press got %0d exp 7", angle); end
    tick();
    checks++; if (angle !== 4'd7) begin errors++; $display("FAIL left_held_no_repeat got %0d exp 7", angle); end
    key_left = 1'b0; tick();
    key_right = 1'b1; tick(); key_right = 1'b0; tick();
    checks++; if (angle !== 4'd8) begin errors++; $display("FAIL right_press got %0d exp 8", angle); end
    key_up = 1'b1; key_down = 1'b1; tick(); key_up = 1'b0; key_down = 1'b0; tick();
    checks++; if (power !== 3'd7) begin errors++; $display("FAIL up_down_cancel got %0d exp 7", power); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL aim_busy got %0b exp 0", busy); end
  endtask

  task automatic test_fire();
    bomb_done = 1'b1;
    key_fire = 1'b1; tick();
    checks++; if (launch !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL fire_launch_busy got %0b%0b exp 11", launch, busy); end
    checks++; if (launchX !== 10'd100 || launchY !== 10'd400) begin errors++; $display("FAIL fire_pos got %0d,%0d exp 100,400", launchX, launchY); end
    key_fire = 1'b0;
    idle(3);
    checks++; if (launch !== 1'b1) begin errors++; $display("FAIL launch_hold got %0b exp 1", launch); end
    tick();
    checks++; if (launch !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL launch_fall got %0b%0b exp 01", launch, busy); end
  endtask

  task automatic test_detonation();
    bomb_done = 1'b1; tick(); tick();
    bomb_done = 1'b0; repeat (4) tick();
    checks++; if (active_player !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL stale_done_ignored got %0b%0b exp 01", active_player, busy); end
    bomb_done = 1'b1; tick();
    tick(); tick(); idle(1);
    checks++; if (active_player !== 1'b0) begin errors++; $display("FAIL settle_early got %0b exp 0", active_player); end
    tick();
    checks++; if (active_player !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL swap_cycle got %0b%0b exp 01", active_player, busy); end
    idle(1);
    checks++; if (active_player !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL swap_done got %0b%0b exp 10", active_player, busy); end
    checks++; if (turn_count !== 8'd1) begin errors++; $display("FAIL turn_count_1 got %0d exp 1", turn_count); end
    checks++; if (angle !== 4'd2 || power !== 3'd3) begin errors++; $display("FAIL p1_aim got %0d/%0d exp 2/3", angle, power); end
  endtask

  task automatic test_timeout_fire_held();
    bomb_done = 1'b0;
    key_fire = 1'b1; tick();
    checks++; if (launch !== 1'b1 || launchX !== 10'd200 || launchY !== 10'd300) begin errors++; $display("FAIL p1_fire got %0b %0d,%0d exp 1 200,300", launch, launchX, launchY); end
    tick();
    repeat (10) tick();
    tick(); tick(); idle(1);
    checks++; if (active_player !== 1'b1) begin errors++; $display("FAIL timeout_early got %0b exp 1", active_player); end
    tick(); idle(1);
    checks++; if (active_player !== 1'b0 || turn_count !== 8'd2 || busy !== 1'b0) begin errors++; $display("FAIL timeout_swap got %0b/%0d/%0b exp 0/2/0", active_player, turn_count, busy); end
    tick(); idle(1);
    checks++; if (launch !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL held_fire_autofire got %0b%0b exp 00", launch, busy); end
    checks++; if (launchX !== 10'd200 || launchY !== 10'd300) begin errors++; $display("FAIL launch_pos_hold got %0d,%0d exp 200,300", launchX, launchY); end
    checks++; if (angle !== 4'd8 || power !== 3'd7) begin errors++; $display("FAIL p0_aim_kept got %0d/%0d exp 8/7", angle, power); end
  endtask

  task automatic test_reset_midflight();
    key_fire = 1'b0; tick();
    key_fire = 1'b1; tick();
    key_fire = 1'b0; tick(); tick();
    #2 reset = 1'b1;
    #1;
    checks++; if (launch !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_flight_launch_busy got %0b%0b exp 00", launch, busy); end
    checks++; if (angle !== 4'd6 || power !== 3'd3 || active_player !== 1'b0) begin errors++; $display("FAIL rst_flight_aim got %0d/%0d/%0b exp 6/3/0", angle, power, active_player); end
    checks++; if (turn_count !== 8'd0 || launchX !== 10'd0) begin errors++; $display("FAIL rst_flight_turn got %0d/%0d exp 0/0", turn_count, launchX); end
    idle(1);
    reset = 1'b0;
    idle(1);
    key_fire = 1'b1; tick();
    checks++; if (launch !== 1'b1) begin errors++; $display("FAIL relaunch got %0b exp 1", launch); end
    #2 reset = 1'b1;
    #1;
    checks++; if (launch !== 1'b0) begin errors++; $display("FAIL rst_async_launch got %0b exp 0", launch); end
    key_fire = 1'b0;
    idle(1);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_aim();
    test_fire();
    test_detonation();
    test_timeout_fire_held();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
